inst_trace_buffer: RTL

INST_TRACE_BUFFER -- requirements
Module: inst_trace_buffer

---
 rtl/mips_defs_pkg.sv | 63 ++++++
 rtl/inst_classify.sv | 43 ++++
 rtl/inst_trace_buffer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants, instruction class codes, trace FSM encoding
// and the trace entry layout used by the trace buffer and its classifier.
package mips_defs_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // REGIMM selects the branch flavour in rt; rt=0 is bltz.
  localparam logic [4:0] RT_BLTZ = 5'h00;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_JR     = 3'd1,
    CLS_IMM    = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JUMP   = 3'd6,
    CLS_OTHER  = 3'd7
  } inst_class_e;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    inst_class_e cls;
  } trace_entry_t;

endpackage

// File: rtl/inst_classify.sv
// Combinational MIPS instruction classifier: instruction word in, 3-bit class out.
module inst_classify
  import mips_defs_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [2:0]  class_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  inst_class_e cls;
  logic        unused_fields;

  assign opcode        = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign rt            = instr_i[20:16];
  assign unused_fields = ^{instr_i[25:21], instr_i[15:6]};

  always_comb begin
    cls = CLS_OTHER;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLL, FN_SRL, FN_SRA, FN_SLT: cls = CLS_ALU;
          FN_JR, FN_JALR:                 cls = CLS_JR;
          default:                        cls = CLS_OTHER;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI: cls = CLS_IMM;
      OP_LW:                          cls = CLS_LOAD;
      OP_SW:                          cls = CLS_STORE;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_BRANCH;
      OP_REGIMM: cls = (rt == RT_BLTZ) ? CLS_BRANCH : CLS_OTHER;
      OP_J, OP_JAL:                   cls = CLS_JUMP;
      default:                        cls = CLS_OTHER;
    endcase
  end

  assign class_o = cls;

endmodule

// File: rtl/inst_trace_buffer.sv
// Circular instruction trace buffer with PC-match trigger, post-trigger capture
// window and a valid/ready drain port once frozen.
module inst_trace_buffer
  import mips_defs_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  input  logic                     rearm,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [2:0]               out_class,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic [1:0]               state_o,
  output logic [31:0]              total_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [31:0]   total_q, total_d;

  trace_entry_t  mem_q [DEPTH];
  trace_entry_t  wr_entry;
  trace_entry_t  head;
  logic [2:0]    in_class;
  logic          capture;
  logic          pop;
  logic          trig_hit;
  logic          wr_en;

  inst_classify u_classify (
    .instr_i (in_instr),
    .class_o (in_class)
  );

  assign wr_entry = '{pc: in_pc, instr: in_instr, cls: inst_class_e'(in_class)};
  assign capture  = in_valid && (state_q != ST_FROZEN);
  assign trig_hit = (state_q == ST_ARMED) && trig_en && (in_pc == trig_pc);
  assign wr_en    = capture && !rearm && !reset;

  // Drain handshake: an entry transfers on a cycle where out_valid && out_ready
  // are both high at the rising edge; out_valid never depends on out_ready.
  assign pop = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    post_cnt_d = post_cnt_q;
    total_d    = (in_valid && (total_q != 32'hFFFF_FFFF)) ? total_q + 32'd1 : total_q;
    if (rearm) begin
      state_d    = ST_ARMED;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      post_cnt_d = '0;
    end else begin
      if (capture) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        // A full buffer keeps the most recent DEPTH entries.
        if (fill_q == FW'(DEPTH)) rd_ptr_d = rd_ptr_q + AW'(1);
        else                      fill_d   = fill_q + FW'(1);
        case (state_q)
          ST_ARMED: begin
            if (trig_hit) begin
              post_cnt_d = AW'(POST_TRIG);
              state_d    = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
            end
          end
          ST_POST: begin
            post_cnt_d = post_cnt_q - AW'(1);
            if (post_cnt_q == AW'(1)) state_d = ST_FROZEN;
          end
          default: ;
        endcase
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        fill_d   = fill_q - FW'(1);
        if (fill_q == FW'(1)) state_d = ST_ARMED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARMED;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      post_cnt_q <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      post_cnt_q <= post_cnt_d;
      total_q    <= total_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (state_q == ST_FROZEN) && (fill_q != '0);
  assign out_last    = out_valid && (fill_q == FW'(1));
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_class   = head.cls;
  assign fill_count  = fill_q;
  assign state_o     = state_q;
  assign total_count = total_q;

endmodule
